exe_stage_muldiv: RTL and testbench
===================================

EXE_STAGE_MULDIV -- requirements
Module: exe_stage_muldiv

Interface
REQ-001 SHALL have ports: clk input 1 (clock, rising edge); rst input 1 (reset, asynchronous, active-high).
REQ-002 SHALL have: Flush input 1 (pipeline flush, aborts in-flight multi-cycle op).
REQ-003 SHALL have: WB_EN_EXE input 1, MEM_CMD_EXE input 2, EXE_CMD_EXE input 6, PC input 32, Dst_EXE input 5 (ID/EXE register outputs).
REQ-004 SHALL have: Val1_EXE input 32, Val2_EXE input 32 (reg value or immediate), Reg2_EXE input 32 (store data), is_Immediate_EXE input 1.
REQ-005 SHALL have: fwd_sel_a input 2, fwd_sel_b input 2, MEM_result input 32, WB_value input 32 (forwarding; 00 = own value, 01 = MEM_result, 10 = WB_value, 11 = own value).
REQ-006 SHALL have: ALU_result output 32, Store_data output 32, WB_EN_out output 1, MEM_CMD_out output 2, Dst_out output 5, PC_out output 32, busy output 1 (freeze request to PC/IF/ID/ID-EXE registers).

Function
REQ-007 Operand A SHALL be the fwd_sel_a mux of Val1_EXE; operand B SHALL be Val2_EXE when is_Immediate_EXE=1, else the fwd_sel_b mux of Val2_EXE; Store_data SHALL be the fwd_sel_b mux of Reg2_EXE.
REQ-008 Single-cycle EXE_CMD (hex): 00 ADD, 01 SUB, 02 AND, 03 OR, 04 NOR, 05 XOR, 06 SLL, 07 SRL, 08 SRA (shift amount B[4:0]), 09 SLT (signed, result 0/1); combinational, all arithmetic mod 2^32; undefined codes SHALL give 0.
REQ-009 Multi-cycle EXE_CMD: 10 MUL (low 32 bits of A*B), 11 DIV (signed quotient), 12 REM (signed remainder, sign of dividend).
REQ-010 Multi-cycle FSM states IDLE, BUSY, DONE; IDLE->BUSY when a multi-cycle command is present; BUSY->DONE after 32 iterations; DONE->IDLE unconditionally.
REQ-011 On the IDLE cycle with a multi-cycle command, SHALL capture forwarded operands and clear the 5-bit iteration counter; one shift-add/restoring iteration per BUSY cycle.
REQ-012 busy SHALL be 1 combinationally in IDLE with a multi-cycle command and throughout BUSY; 0 in DONE and otherwise (33 busy cycles per op).
REQ-013 While busy=1, WB_EN_out and MEM_CMD_out SHALL be forced to 0 (bubble into EXE/MEM); in DONE they SHALL pass through and ALU_result SHALL equal the registered result.
REQ-014 A multi-cycle command seen in DONE SHALL NOT restart; a multi-cycle command arriving in the next IDLE cycle SHALL start normally (back-to-back allowed).
REQ-015 DIV/REM by zero: quotient 32'hFFFFFFFF, remainder = dividend; 32'h80000000 / 32'hFFFFFFFF: quotient 32'h80000000, remainder 0.
REQ-016 Flush=1 in any state SHALL return FSM to IDLE next edge, deassert busy in the same cycle, and force WB_EN_out=0, MEM_CMD_out=0 in that cycle.
REQ-017 Dst_out and PC_out SHALL pass Dst_EXE and PC unmodified in every state.

Reset
REQ-018 rst SHALL asynchronously set FSM=IDLE, counter=0, operand/accumulator/result registers=0; with a non-multi-cycle command present, busy=0.
REQ-019 rst asserted mid-operation SHALL discard the operation; no partial result SHALL appear on ALU_result afterwards.

Configuration
REQ-020 Macro EXE_MULDIV_EN defined: REQ-009..REQ-016 multi-cycle behaviour present.
REQ-021 EXE_MULDIV_EN undefined: no FSM/datapath registers; busy tied 0; commands 10-12 SHALL give ALU_result=0 with WB_EN_out=0 and MEM_CMD_out=0.

Verification
REQ-022 ADD A=7, B=imm 32'hFFFFFFFF, is_Immediate=1 -> ALU_result=6 same cycle, busy=0.
REQ-023 SUB with fwd_sel_a=01, MEM_result=100, Val2=30 -> ALU_result=70; Store_data follows fwd_sel_b=10 -> WB_value.
REQ-024 MUL A=-3, B=5 -> busy=1 for 33 cycles, WB_EN_out=0 during, DONE cycle ALU_result=32'hFFFFFFF1, WB_EN_out=1.
REQ-025 DIV -7/2 -> -3; REM -7/2 -> -1; DIV 5/0 -> 32'hFFFFFFFF; REM 5/0 -> 5; DIV 32'h80000000/-1 -> 32'h80000000.
REQ-026 Flush at BUSY cycle 10 -> busy=0 same cycle, FSM IDLE next edge; rst at BUSY cycle 5 -> busy=0 immediately, following ADD executes single-cycle.
REQ-027 Build without EXE_MULDIV_EN, issue MUL -> busy never 1, ALU_result=0, WB_EN_out=0.

Source files
------------

// File: rtl/exe_stage_muldiv.sv
// Execute stage: forwarding muxes, single-cycle ALU and an optional iterative MUL/DIV/REM unit.
// Define EXE_MULDIV_EN to build the multi-cycle unit; without it busy is tied low.
module exe_stage_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        Flush,
  input  logic        WB_EN_EXE,
  input  logic [1:0]  MEM_CMD_EXE,
  input  logic [5:0]  EXE_CMD_EXE,
  input  logic [31:0] PC,
  input  logic [4:0]  Dst_EXE,
  input  logic [31:0] Val1_EXE,
  input  logic [31:0] Val2_EXE,
  input  logic [31:0] Reg2_EXE,
  input  logic        is_Immediate_EXE,
  input  logic [1:0]  fwd_sel_a,
  input  logic [1:0]  fwd_sel_b,
  input  logic [31:0] MEM_result,
  input  logic [31:0] WB_value,
  output logic [31:0] ALU_result,
  output logic [31:0] Store_data,
  output logic        WB_EN_out,
  output logic [1:0]  MEM_CMD_out,
  output logic [4:0]  Dst_out,
  output logic [31:0] PC_out,
  output logic        busy
);

  function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] own,
                                          input logic [31:0] mem, input logic [31:0] wb);
    case (sel)
      2'b01:   return mem;
      2'b10:   return wb;
      default: return own;
    endcase
  endfunction

  logic        [31:0] op_a, op_b, alu_sc;
  logic signed [31:0] op_a_s, op_b_s;
  logic               is_mc, kill;

  assign op_a       = fwd_mux(fwd_sel_a, Val1_EXE, MEM_result, WB_value);
  assign op_b       = is_Immediate_EXE ? Val2_EXE : fwd_mux(fwd_sel_b, Val2_EXE, MEM_result, WB_value);
  assign op_a_s     = op_a;
  assign op_b_s     = op_b;
  assign Store_data = fwd_mux(fwd_sel_b, Reg2_EXE, MEM_result, WB_value);
  assign is_mc      = (EXE_CMD_EXE == 6'h10) || (EXE_CMD_EXE == 6'h11) || (EXE_CMD_EXE == 6'h12);
  assign Dst_out    = Dst_EXE;
  assign PC_out     = PC;

  always_comb begin
    alu_sc = '0;
    case (EXE_CMD_EXE)
      6'h00:   alu_sc = op_a + op_b;
      6'h01:   alu_sc = op_a - op_b;
      6'h02:   alu_sc = op_a & op_b;
      6'h03:   alu_sc = op_a | op_b;
      6'h04:   alu_sc = ~(op_a | op_b);
      6'h05:   alu_sc = op_a ^ op_b;
      6'h06:   alu_sc = op_a << op_b[4:0];
      6'h07:   alu_sc = op_a >> op_b[4:0];
      6'h08:   alu_sc = op_a_s >>> op_b[4:0];
      6'h09:   alu_sc = {31'd0, (op_a_s < op_b_s)};
      default: alu_sc = '0;
    endcase
  end

`ifdef EXE_MULDIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  // Sign restoration of the unsigned restoring-division result; MUL passes straight through.
  function automatic logic [31:0] md_result(input logic [1:0] op, input logic [31:0] quo,
                                            input logic [31:0] acc, input logic neg_a,
                                            input logic neg_b, input logic divz);
    case (op)
      2'b00:   return acc;
      2'b01:   return divz ? 32'hFFFF_FFFF : ((neg_a ^ neg_b) ? -quo : quo);
      2'b10:   return neg_a ? -acc : acc;
      default: return '0;
    endcase
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d, acc_q, acc_d, res_q, res_d;
  logic [1:0]  op_q, op_d;
  logic        neg_a_q, neg_a_d, neg_b_q, neg_b_d, divz_q, divz_d;
  logic [32:0] rem_sh;
  logic        mc_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      op_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      divz_q  <= divz_d;
    end
  end

  // opa holds multiplicand / dividend-then-quotient; acc holds product / partial remainder.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    res_d   = res_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    divz_d  = divz_q;
    rem_sh  = '0;
    mc_busy = 1'b0;
    if (Flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (is_mc) begin
          mc_busy = 1'b1;
          state_d = BUSY;
          cnt_d   = '0;
          acc_d   = '0;
          op_d    = EXE_CMD_EXE[1:0];
          neg_a_d = op_a[31];
          neg_b_d = op_b[31];
          divz_d  = (op_b == 32'd0);
          opa_d   = (EXE_CMD_EXE[1:0] == 2'b00) ? op_a : mag(op_a);
          opb_d   = (EXE_CMD_EXE[1:0] == 2'b00) ? op_b : mag(op_b);
        end
        BUSY: begin
          mc_busy = 1'b1;
          cnt_d   = cnt_q + 5'd1;
          if (op_q == 2'b00) begin
            if (opb_q[0]) acc_d = acc_q + opa_q;
            opa_d = {opa_q[30:0], 1'b0};
            opb_d = {1'b0, opb_q[31:1]};
          end else begin
            rem_sh = {acc_q, opa_q[31]};
            opa_d  = {opa_q[30:0], 1'b0};
            if (rem_sh >= {1'b0, opb_q}) begin
              acc_d    = rem_sh[31:0] - opb_q;
              opa_d[0] = 1'b1;
            end else begin
              acc_d = rem_sh[31:0];
            end
          end
          if (cnt_q == 5'd31) begin
            state_d = DONE;
            res_d   = md_result(op_q, opa_d, acc_d, neg_a_q, neg_b_q, divz_q);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = mc_busy;
    ALU_result  = (state_q == DONE) ? res_q : alu_sc;
    kill        = Flush | mc_busy | (is_mc & (state_q != DONE));
    WB_EN_out   = kill ? 1'b0 : WB_EN_EXE;
    MEM_CMD_out = kill ? 2'b00 : MEM_CMD_EXE;
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  always_comb begin
    busy        = 1'b0;
    ALU_result  = alu_sc;
    kill        = Flush | is_mc;
    WB_EN_out   = kill ? 1'b0 : WB_EN_EXE;
    MEM_CMD_out = kill ? 2'b00 : MEM_CMD_EXE;
  end
`endif

endmodule

// File: tb/tb_exe_stage_muldiv.sv
// Directed testbench for exe_stage_muldiv; multi-cycle scenarios run when EXE_MULDIV_EN is defined.
module tb_exe_stage_muldiv;
  logic        clk = 1'b0;
  logic        rst, Flush, WB_EN_EXE, is_Immediate_EXE;
  logic [1:0]  MEM_CMD_EXE, fwd_sel_a, fwd_sel_b, MEM_CMD_out;
  logic [5:0]  EXE_CMD_EXE;
  logic [31:0] PC, Val1_EXE, Val2_EXE, Reg2_EXE, MEM_result, WB_value;
  logic [31:0] ALU_result, Store_data, PC_out;
  logic [4:0]  Dst_EXE, Dst_out;
  logic        WB_EN_out, busy;

  int vec = 0;
  int errs = 0;

  always #5 clk = ~clk;

  exe_stage_muldiv dut (
    .clk(clk), .rst(rst), .Flush(Flush), .WB_EN_EXE(WB_EN_EXE), .MEM_CMD_EXE(MEM_CMD_EXE),
    .EXE_CMD_EXE(EXE_CMD_EXE), .PC(PC), .Dst_EXE(Dst_EXE), .Val1_EXE(Val1_EXE),
    .Val2_EXE(Val2_EXE), .Reg2_EXE(Reg2_EXE), .is_Immediate_EXE(is_Immediate_EXE),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .MEM_result(MEM_result), .WB_value(WB_value),
    .ALU_result(ALU_result), .Store_data(Store_data), .WB_EN_out(WB_EN_out),
    .MEM_CMD_out(MEM_CMD_out), .Dst_out(Dst_out), .PC_out(PC_out), .busy(busy)
  );

  logic [5:0]  t_cmd [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                               6'h08, 6'h08, 6'h09, 6'h09, 6'h01, 6'h0A, 6'h3F};
  logic [31:0] t_a   [14] = '{32'h7, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0000FFFF, 32'hAAAA5555,
                               32'h1, 32'h80000000, 32'h80000000, 32'h40000000, 32'hFFFFFFFF,
                               32'h1, 32'h0, 32'h12345678, 32'h1};
  logic [31:0] t_b   [14] = '{32'hFFFFFFFF, 32'hFF00FF00, 32'h0F0F0F0F, 32'h00FF0000, 32'hFFFF0000,
                               32'h21, 32'h4, 32'h4, 32'h1F, 32'h1, 32'hFFFFFFFF, 32'h1, 32'h9, 32'h1};
  logic [31:0] t_exp [14] = '{32'h6, 32'hF000F000, 32'hFFFFFFFF, 32'hFF000000, 32'h55555555,
                               32'h2, 32'h08000000, 32'hF8000000, 32'h0, 32'h1, 32'h0,
                               32'hFFFFFFFF, 32'h0, 32'h0};

  task automatic apply(input logic [5:0] cmd, input logic [31:0] a, input logic [31:0] b);
    EXE_CMD_EXE      = cmd;
    Val1_EXE         = a;
    Val2_EXE         = b;
    is_Immediate_EXE = 1'b1;
    fwd_sel_a        = 2'b00;
    fwd_sel_b        = 2'b00;
  endtask

  task automatic test_reset;
    apply(6'h00, 32'd3, 32'd4);
    #2;
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec++; if (ALU_result !== 32'd7) begin errs++; $display("FAIL reset_alu: got %h want 7", ALU_result); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    vec++; if (WB_EN_out !== 1'b1 || MEM_CMD_out !== 2'b01) begin
      errs++; $display("FAIL post_reset_ctrl: got wb=%b mem=%b want 1/01", WB_EN_out, MEM_CMD_out); end
  endtask

  task automatic test_alu;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      apply(t_cmd[i], t_a[i], t_b[i]);
      #1;
      vec++; if (ALU_result !== t_exp[i]) begin
        errs++; $display("FAIL alu_%0d cmd=%h: got %h want %h", i, t_cmd[i], ALU_result, t_exp[i]); end
      vec++; if (busy !== 1'b0) begin errs++; $display("FAIL alu_busy_%0d: got %b want 0", i, busy); end
    end
  endtask

  task automatic test_forwarding;
    @(negedge clk);
    apply(6'h01, 32'd999, 32'd30);
    fwd_sel_a = 2'b01; MEM_result = 32'd100; fwd_sel_b = 2'b10; WB_value = 32'h1234; Reg2_EXE = 32'h55;
    #1;
    vec++; if (ALU_result !== 32'd70) begin errs++; $display("FAIL fwd_sub: got %0d want 70", ALU_result); end
    vec++; if (Store_data !== 32'h1234) begin errs++; $display("FAIL fwd_store_wb: got %h want 1234", Store_data); end
    @(negedge clk);
    apply(6'h00, 32'd1, 32'd7);
    is_Immediate_EXE = 1'b0; fwd_sel_a = 2'b10; WB_value = 32'h1000; fwd_sel_b = 2'b01; MEM_result = 32'h20;
    #1;
    vec++; if (ALU_result !== 32'h1020) begin errs++; $display("FAIL fwd_add_wb_mem: got %h want 1020", ALU_result); end
    vec++; if (Store_data !== 32'h20) begin errs++; $display("FAIL fwd_store_mem: got %h want 20", Store_data); end
    @(negedge clk);
    apply(6'h00, 32'd3, 32'd4);
    is_Immediate_EXE = 1'b0; fwd_sel_a = 2'b11; fwd_sel_b = 2'b11; Reg2_EXE = 32'h55;
    #1;
    vec++; if (ALU_result !== 32'd7) begin errs++; $display("FAIL fwd_sel11: got %h want 7", ALU_result); end
    vec++; if (Store_data !== 32'h55) begin errs++; $display("FAIL fwd_store_own: got %h want 55", Store_data); end
    @(negedge clk);
    apply(6'h00, 32'd0, 32'd0);
  endtask

  task automatic test_flush_single;
    @(negedge clk);
    apply(6'h00, 32'd1, 32'd1);
    Flush = 1'b1;
    #1;
    vec++; if (WB_EN_out !== 1'b0 || MEM_CMD_out !== 2'b00 || busy !== 1'b0) begin
      errs++; $display("FAIL flush_single: got wb=%b mem=%b busy=%b want 0/00/0", WB_EN_out, MEM_CMD_out, busy); end
    Flush = 1'b0;
    #1;
    vec++; if (WB_EN_out !== 1'b1) begin errs++; $display("FAIL flush_release: got wb=%b want 1", WB_EN_out); end
  endtask

  task automatic test_passthrough;
    @(negedge clk);
    Dst_EXE = 5'd17; PC = 32'hDEAD_0010;
    #1;
    vec++; if (Dst_out !== 5'd17 || PC_out !== 32'hDEAD_0010) begin
      errs++; $display("FAIL passthrough: got dst=%0d pc=%h want 17/dead0010", Dst_out, PC_out); end
  endtask

`ifdef EXE_MULDIV_EN
  task automatic run_mc(input logic [5:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expv, input string nm, input bit chain);
    int  nb;
    bit  ctl_bad;
    @(negedge clk);
    apply(cmd, a, b);
    #1;
    vec++; if (busy !== 1'b1 || WB_EN_out !== 1'b0) begin
      errs++; $display("FAIL %s_start: got busy=%b wb=%b want 1/0", nm, busy, WB_EN_out); end
    nb = 1; ctl_bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (busy !== 1'b1) break;
      nb++;
      if (WB_EN_out !== 1'b0 || MEM_CMD_out !== 2'b00 || Dst_out !== Dst_EXE) ctl_bad = 1;
    end
    vec++; if (nb != 33) begin errs++; $display("FAIL %s_busy_cycles: got %0d want 33", nm, nb); end
    vec++; if (ctl_bad) begin errs++; $display("FAIL %s_bubble: got wb/mem nonzero while busy want 0", nm); end
    vec++; if (ALU_result !== expv) begin errs++; $display("FAIL %s_result: got %h want %h", nm, ALU_result, expv); end
    vec++; if (WB_EN_out !== 1'b1 || MEM_CMD_out !== 2'b01) begin
      errs++; $display("FAIL %s_done_ctrl: got wb=%b mem=%b want 1/01", nm, WB_EN_out, MEM_CMD_out); end
    if (!chain) begin
      apply(6'h00, 32'd0, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_muldiv;
    run_mc(6'h10, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, "mul_neg", 0);
    run_mc(6'h11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_neg", 0);
    run_mc(6'h12, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_neg", 0);
    run_mc(6'h12, 32'd7, 32'hFFFFFFFE, 32'd1, "rem_negdivisor", 0);
    run_mc(6'h11, 32'd5, 32'd0, 32'hFFFFFFFF, "div_zero", 0);
    run_mc(6'h12, 32'd5, 32'd0, 32'd5, "rem_zero", 0);
    run_mc(6'h11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf", 0);
    run_mc(6'h12, 32'h80000000, 32'hFFFFFFFF, 32'd0, "rem_ovf", 0);
  endtask

  task automatic test_back_to_back;
    int nb;
    run_mc(6'h10, 32'd6, 32'd7, 32'd42, "b2b_mul", 1);
    apply(6'h11, 32'd100, 32'd7);
    #1;
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL b2b_no_restart_in_done: got busy=%b want 0", busy); end
    @(posedge clk); #1;
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL b2b_start: got busy=%b want 1", busy); end
    nb = 1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (busy !== 1'b1) break;
      nb++;
    end
    vec++; if (nb != 33) begin errs++; $display("FAIL b2b_busy_cycles: got %0d want 33", nb); end
    vec++; if (ALU_result !== 32'd14) begin errs++; $display("FAIL b2b_div: got %0d want 14", ALU_result); end
    apply(6'h00, 32'd0, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic test_flush_mc;
    @(negedge clk);
    apply(6'h10, 32'd3, 32'd3);
    for (int k = 0; k < 10; k++) @(posedge clk);
    #1;
    Flush = 1'b1;
    #1;
    vec++; if (busy !== 1'b0 || WB_EN_out !== 1'b0 || MEM_CMD_out !== 2'b00) begin
      errs++; $display("FAIL flush_mc: got busy=%b wb=%b mem=%b want 0/0/00", busy, WB_EN_out, MEM_CMD_out); end
    @(posedge clk); #1;
    Flush = 1'b0;
    apply(6'h00, 32'd2, 32'd3);
    #1;
    vec++; if (busy !== 1'b0 || ALU_result !== 32'd5) begin
      errs++; $display("FAIL flush_idle: got busy=%b alu=%h want 0/5", busy, ALU_result); end
    @(posedge clk); #1;
    run_mc(6'h10, 32'd3, 32'd3, 32'd9, "mul_after_flush", 0);
  endtask

  task automatic test_rst_mc;
    @(negedge clk);
    apply(6'h11, 32'd100, 32'd3);
    for (int k = 0; k < 5; k++) @(posedge clk);
    #1;
    rst = 1'b1;
    apply(6'h00, 32'd10, 32'd20);
    #1;
    vec++; if (busy !== 1'b0 || ALU_result !== 32'd30) begin
      errs++; $display("FAIL rst_mid_op: got busy=%b alu=%h want 0/1e", busy, ALU_result); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    vec++; if (busy !== 1'b0 || ALU_result !== 32'd30 || WB_EN_out !== 1'b1) begin
      errs++; $display("FAIL rst_then_add: got busy=%b alu=%h wb=%b want 0/1e/1", busy, ALU_result, WB_EN_out); end
    run_mc(6'h11, 32'd100, 32'd3, 32'd33, "div_after_rst", 0);
  endtask
`else
  task automatic test_no_muldiv;
    bit seen_busy;
    bit ctl_bad;
    seen_busy = 0; ctl_bad = 0;
    @(negedge clk);
    apply(6'h10, 32'hFFFFFFFD, 32'd5);
    for (int k = 0; k < 40; k++) begin
      #1;
      if (busy !== 1'b0) seen_busy = 1;
      if (ALU_result !== 32'd0 || WB_EN_out !== 1'b0 || MEM_CMD_out !== 2'b00) ctl_bad = 1;
      @(negedge clk);
    end
    vec++; if (seen_busy) begin errs++; $display("FAIL nomd_busy: got busy=1 want never"); end
    vec++; if (ctl_bad) begin errs++; $display("FAIL nomd_mul_outputs: got nonzero alu/wb/mem want 0"); end
    apply(6'h11, 32'd100, 32'd7);
    #1;
    vec++; if (ALU_result !== 32'd0 || WB_EN_out !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL nomd_div: got alu=%h wb=%b busy=%b want 0/0/0", ALU_result, WB_EN_out, busy); end
    apply(6'h12, 32'd100, 32'd7);
    #1;
    vec++; if (ALU_result !== 32'd0 || MEM_CMD_out !== 2'b00) begin
      errs++; $display("FAIL nomd_rem: got alu=%h mem=%b want 0/00", ALU_result, MEM_CMD_out); end
    @(negedge clk);
    apply(6'h00, 32'd0, 32'd0);
  endtask
`endif

  initial begin
    rst = 1'b1; Flush = 1'b0; WB_EN_EXE = 1'b1; MEM_CMD_EXE = 2'b01; Dst_EXE = 5'd9; PC = 32'h400;
    Reg2_EXE = 32'h0; MEM_result = 32'h0; WB_value = 32'h0;
    apply(6'h00, 32'd0, 32'd0);
    test_reset();
    test_alu();
    test_forwarding();
    test_flush_single();
    test_passthrough();
`ifdef EXE_MULDIV_EN
    test_muldiv();
    test_back_to_back();
    test_flush_mc();
    test_rst_mc();
`else
    test_no_muldiv();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
